// File: rtl/rev_gpio_debounce.sv
// Per-pin GPIO debounce filter with shared sample prescaler, per-pin bypass and edge pulses.
// Define REV_GPIO_DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the filter.
module rev_gpio_debounce #(
  parameter int GPIO_PINS = 32,
  parameter int CNT_W     = 4,
  parameter int PRESC_W   = 16
) (
  input  logic                 pclk,
  input  logic                 prst,
  input  logic [GPIO_PINS-1:0] pad_i,
  input  logic [PRESC_W-1:0]   presc_i,
  input  logic [CNT_W-1:0]     thresh_i,
  input  logic [GPIO_PINS-1:0] bypass_i,
  output logic [GPIO_PINS-1:0] gpio_o,
  output logic [GPIO_PINS-1:0] rise_o,
  output logic [GPIO_PINS-1:0] fall_o,
  output logic                 tick_o
);

  logic [GPIO_PINS-1:0] s;

`ifdef REV_GPIO_DEBOUNCE_SYNC_EN
  logic [GPIO_PINS-1:0] sync1_q, sync2_q;

  always_ff @(posedge pclk) begin
    if (prst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = pad_i;
`endif

  // Prescaler: comparing with >= lets a lowered presc_i take effect on the next cycle.
  logic [PRESC_W-1:0] pc_q;
  logic               tick;

  assign tick   = prst ? (presc_i == '0) : (pc_q >= presc_i);
  assign tick_o = tick;

  always_ff @(posedge pclk) begin
    if (prst)      pc_q <= '0;
    else if (tick) pc_q <= '0;
    else           pc_q <= pc_q + 1'b1;
  end

  logic [CNT_W-1:0] thr;
  assign thr = (thresh_i == '0) ? CNT_W'(1) : thresh_i;

  logic [GPIO_PINS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [GPIO_PINS-1:0]            gpio_d;
  logic [CNT_W:0]                  cnt_inc;

  always_comb begin
    // NOTE: every comb output gets a default before the per-pin branches, so no latch is inferred.
    gpio_d  = gpio_o;
    cnt_d   = cnt_q;
    cnt_inc = '0;
    for (int n = 0; n < GPIO_PINS; n++) begin
      cnt_inc = {1'b0, cnt_q[n]} + 1'b1;
      if (bypass_i[n]) begin
        gpio_d[n] = s[n];
        cnt_d[n]  = '0;
      end else if (tick) begin
        if (s[n] == gpio_o[n]) begin
          cnt_d[n] = '0;
        end else if (cnt_inc >= {1'b0, thr}) begin
          gpio_d[n] = s[n];
          cnt_d[n]  = '0;
        end else begin
          cnt_d[n] = cnt_inc[CNT_W-1:0];
        end
      end
    end
  end

  // Edge pulses are derived from the next value so they line up with the new gpio_o level.
  always_ff @(posedge pclk) begin
    if (prst) begin
      gpio_o <= '0;
      rise_o <= '0;
      fall_o <= '0;
      cnt_q  <= '0;
    end else begin
      gpio_o <= gpio_d;
      rise_o <= gpio_d & ~gpio_o;
      fall_o <= ~gpio_d & gpio_o;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rev_gpio_debounce.sv
// Scenario bench for rev_gpio_debounce: expected observations are queued before each edge and popped after it.
module tb_rev_gpio_debounce;
  localparam int N = 8;
`ifdef REV_GPIO_DEBOUNCE_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  typedef struct packed {
    logic [N-1:0] g;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic         t;
  } obs_t;

  logic          pclk = 1'b0;
  logic          prst = 1'b1;
  logic [N-1:0]  pad_i = '0;
  logic [N-1:0]  bypass_i = '0;
  logic [15:0]   presc_i = '0;
  logic [3:0]    thresh_i = 4'd1;
  logic [N-1:0]  gpio_o, rise_o, fall_o;
  logic          tick_o;

  obs_t         sb[$];
  obs_t         obs, exp_v;
  logic [N-1:0] g_prev = '0;
  logic [N-1:0] g_exp;
  int           vectors = 0;
  int           miscompares = 0;

  rev_gpio_debounce #(.GPIO_PINS(N), .CNT_W(4), .PRESC_W(16)) dut (
    .pclk     (pclk),
    .prst     (prst),
    .pad_i    (pad_i),
    .presc_i  (presc_i),
    .thresh_i (thresh_i),
    .bypass_i (bypass_i),
    .gpio_o   (gpio_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .tick_o   (tick_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic push_filtered(input logic [N-1:0] g, input logic t);
    sb.push_back('{g, g & ~g_prev, ~g & g_prev, t});
    g_prev = g;
  endtask

  task automatic edge_wait();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    presc_i = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) presc_i = 16'd5;
      sb.push_back('{8'h00, 8'h00, 8'h00, (i < 2)});
      g_prev = '0;
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
    prst = 1'b0;
  endtask

  task automatic test_filter_rise();
    presc_i = '0;
    thresh_i = 4'd4;
    pad_i[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_filtered((i >= 3 + L) ? 8'h01 : 8'h00, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL filter_rise i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 10; i++) begin
      pad_i[3] = (i < 3);
      push_filtered(8'h01, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL glitch i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
  endtask

  task automatic test_prescaler();
    thresh_i = 4'd1;
    pad_i[7] = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      push_filtered((i >= L) ? 8'h81 : 8'h01, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL presc_setup i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
    presc_i = 16'd9;
    thresh_i = 4'd2;
    pad_i[7] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      push_filtered((i >= 19) ? 8'h01 : 8'h81, (i % 10 == 8));
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL presc_fall i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
  endtask

  task automatic test_bypass();
    logic g5;
    for (int i = 0; i < 10; i++) begin
      bypass_i[5] = (i < 8);
      pad_i[5] = (i < 8) && (i % 2 == 0);
      g5 = (i < 8 && i >= L) ? ((i - L) % 2 == 0) : 1'b0;
      push_filtered({2'b00, g5, 5'b00001}, (i % 10 == 8));
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL bypass i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    presc_i = '0;
    thresh_i = 4'd3;
    pad_i[2] = 1'b1;
    for (int i = 0; i < 2 + L; i++) begin
      push_filtered(8'h01, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL mid_pre i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      prst = 1'b1;
      presc_i = (pass == 0) ? 16'd0 : 16'd3;
      for (int i = 0; i < 2; i++) begin
        sb.push_back('{8'h00, 8'h00, 8'h00, (pass == 0)});
        g_prev = '0;
        edge_wait();
        obs = '{gpio_o, rise_o, fall_o, tick_o};
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL mid_reset p=%0d i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                   pass, i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
        end
      end
      prst = 1'b0;
      for (int j = 0; j < ((pass == 0) ? 6 : 13); j++) begin
        if (pass == 0) push_filtered((j >= 2 + L) ? 8'h05 : 8'h00, 1'b1);
        else           push_filtered((j >= 11) ? 8'h05 : 8'h00, (j % 4 == 2));
        edge_wait();
        obs = '{gpio_o, rise_o, fall_o, tick_o};
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL mid_release p=%0d j=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                   pass, j, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
        end
      end
    end
  endtask

  task automatic test_thresh_zero_and_all_pins();
    presc_i = '0;
    thresh_i = 4'd0;
    pad_i[4] = 1'b1;
    for (int i = 0; i < L + 2; i++) begin
      push_filtered((i >= L) ? 8'h15 : 8'h05, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL thresh0 i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
    thresh_i = 4'd1;
    pad_i = 8'hEA;
    for (int i = 0; i < L + 2; i++) begin
      push_filtered((i >= L) ? 8'hEA : 8'h15, 1'b1);
      edge_wait();
      obs = '{gpio_o, rise_o, fall_o, tick_o};
      exp_v = sb.pop_front();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL all_pins i=%0d: got g=%h r=%h f=%h t=%b, want g=%h r=%h f=%h t=%b",
                 i, obs.g, obs.r, obs.f, obs.t, exp_v.g, exp_v.r, exp_v.f, exp_v.t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_filter_rise();
    test_glitch();
    test_prescaler();
    test_bypass();
    test_reset_mid_count();
    test_thresh_zero_and_all_pins();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
